// File: rtl/wb_trace.sv
// Write-back trace FIFO: captures processor write-back words and streams them to a host
// over a valid/ready port. Optional drop counter is enabled by WB_TRACE_OVF_CNT_EN.
`ifndef WIDTH
`define WIDTH 7
`endif

module wb_trace #(
  parameter int DEPTH  = 8,
  parameter bit FREEZE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [`WIDTH:0]          wd,
  input  logic                     clr,
  input  logic                     tready,
  output logic                     tvalid,
  output logic [`WIDTH:0]          tdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     ovf
`ifdef WB_TRACE_OVF_CNT_EN
  ,
  output logic [7:0]               ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              ovf_q, ovf_d;
  logic [`WIDTH:0]   mem [DEPTH];

  logic is_full, pop, push, drop;

  assign is_full = (level_q == DEPTH_L);
  assign pop     = (level_q != '0) && tready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign push    = (state_q == ST_RUN) && we && (!is_full || pop);
  assign drop    = (state_q == ST_RUN) && we && is_full && !pop;

  // NOTE: every next-state variable gets its default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (clr) begin
      state_d  = ST_RUN;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
      if (drop) begin
        ovf_d = 1'b1;
        if (FREEZE) state_d = ST_HALT;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage is deliberately not reset; tdata is masked to 0 while the FIFO is empty instead.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr_q] <= wd;
  end

`ifdef WB_TRACE_OVF_CNT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       cnt_inc;

  // While halted every capture request is counted as a drop.
  assign cnt_inc = we && ((state_q == ST_HALT) || (is_full && !pop));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                           cnt_d = '0;
    else if (cnt_inc && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign ovf_cnt = cnt_q;
`endif

  assign tvalid = (level_q != '0);
  assign tdata  = tvalid ? mem[rd_ptr_q] : '0;
  assign level  = level_q;
  assign full   = is_full;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_wb_trace.sv
// Bench for wb_trace: a keep-running and a freeze instance share stimulus; a queue model
// per instance is compared every cycle, and directed literal checks pin the model.
`ifndef WIDTH
`define WIDTH 7
`endif

module tb_wb_trace;

  localparam int DEPTH = 8;
  localparam int W     = `WIDTH + 1;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         we = 1'b0, clr = 1'b0, tready = 1'b0;
  logic [W-1:0] wd = '0;

  logic          tvalid_o [2];
  logic [W-1:0]  tdata_o  [2];
  logic [LW-1:0] level_o  [2];
  logic          full_o   [2];
  logic          ovf_o    [2];
`ifdef WB_TRACE_OVF_CNT_EN
  logic [7:0]    cnt_o    [2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_trace #(.DEPTH(DEPTH), .FREEZE(1'b0)) u_run (
    .clk(clk), .rst(rst), .we(we), .wd(wd), .clr(clr), .tready(tready),
    .tvalid(tvalid_o[0]), .tdata(tdata_o[0]), .level(level_o[0]),
    .full(full_o[0]), .ovf(ovf_o[0])
`ifdef WB_TRACE_OVF_CNT_EN
    , .ovf_cnt(cnt_o[0])
`endif
  );

  wb_trace #(.DEPTH(DEPTH), .FREEZE(1'b1)) u_frz (
    .clk(clk), .rst(rst), .we(we), .wd(wd), .clr(clr), .tready(tready),
    .tvalid(tvalid_o[1]), .tdata(tdata_o[1]), .level(level_o[1]),
    .full(full_o[1]), .ovf(ovf_o[1])
`ifdef WB_TRACE_OVF_CNT_EN
    , .ovf_cnt(cnt_o[1])
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: one queue per instance, index 1 is the freezing one.
  logic [W-1:0] mq [2][$];
  bit           m_ovf  [2];
  bit           m_halt [2];
  int           m_cnt  [2];

  initial begin
    bit m_pop, m_acc;
    forever begin
      @(posedge clk or posedge rst);
      for (int f = 0; f < 2; f++) begin
        if (rst || clr) begin
          mq[f].delete();
          m_ovf[f]  = 1'b0;
          m_halt[f] = 1'b0;
          m_cnt[f]  = 0;
        end else begin
          m_pop = (mq[f].size() > 0) && tready;
          m_acc = 1'b0;
          if (m_halt[f]) begin
            if (we && m_cnt[f] < 255) m_cnt[f]++;
          end else if (we) begin
            if (mq[f].size() < DEPTH || m_pop) m_acc = 1'b1;
            else begin
              m_ovf[f] = 1'b1;
              if (m_cnt[f] < 255) m_cnt[f]++;
              if (f == 1) m_halt[f] = 1'b1;
            end
          end
          if (m_pop) void'(mq[f].pop_front());
          if (m_acc) mq[f].push_back(wd);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int f = 0; f < 2; f++) begin
          check($sformatf("i%0d level", f), 32'(level_o[f]), 32'(mq[f].size()));
          check($sformatf("i%0d tvalid", f), 32'(tvalid_o[f]), 32'(mq[f].size() > 0));
          check($sformatf("i%0d tdata", f), 32'(tdata_o[f]),
                (mq[f].size() > 0) ? 32'(mq[f][0]) : 32'd0);
          check($sformatf("i%0d full", f), 32'(full_o[f]), 32'(mq[f].size() == DEPTH));
          check($sformatf("i%0d ovf", f), 32'(ovf_o[f]), 32'(m_ovf[f]));
`ifdef WB_TRACE_OVF_CNT_EN
          check($sformatf("i%0d ovf_cnt", f), 32'(cnt_o[f]), 32'(m_cnt[f]));
`endif
        end
      end
    end
  end

  // Inputs change right after a falling edge and are held across the next rising edge.
  task automatic cyc(input logic w, input logic [W-1:0] d, input logic r, input logic c);
    we = w; wd = d; tready = r; clr = c;
    @(negedge clk);
    we = 1'b0; tready = 1'b0; clr = 1'b0;
  endtask

  initial begin
    logic [W-1:0] exp_tail [8];
    int nexp, maxlvl;

    repeat (2) @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      check($sformatf("rst i%0d tvalid", f), 32'(tvalid_o[f]), 32'd0);
      check($sformatf("rst i%0d level", f), 32'(level_o[f]), 32'd0);
      check($sformatf("rst i%0d tdata", f), 32'(tdata_o[f]), 32'd0);
      check($sformatf("rst i%0d full", f), 32'(full_o[f]), 32'd0);
      check($sformatf("rst i%0d ovf", f), 32'(ovf_o[f]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Basic ordering
    cyc(1, 8'h11, 0, 0); cyc(1, 8'h22, 0, 0); cyc(1, 8'h33, 0, 0);
    check("order level3", 32'(level_o[0]), 32'd3);
    check("order head", 32'(tdata_o[0]), 32'h11);
    cyc(0, 0, 1, 0); check("order 2nd", 32'(tdata_o[0]), 32'h22);
    cyc(0, 0, 1, 0); check("order 3rd", 32'(tdata_o[0]), 32'h33);
    cyc(0, 0, 1, 0); check("order empty", 32'(tvalid_o[0]), 32'd0);
    cyc(0, 0, 1, 0); check("empty pop level", 32'(level_o[0]), 32'd0);

    // Overflow while keep-running
    cyc(0, 0, 0, 1);
    for (int i = 1; i <= 9; i++) cyc(1, W'(i), 0, 0);
    check("ovf full", 32'(full_o[0]), 32'd1);
    check("ovf level", 32'(level_o[0]), 32'd8);
    check("ovf flag", 32'(ovf_o[0]), 32'd1);
`ifdef WB_TRACE_OVF_CNT_EN
    check("ovf cnt", 32'(cnt_o[0]), 32'd1);
`endif
    for (int i = 1; i <= 8; i++) begin
      check("ovf drain", 32'(tdata_o[0]), 32'(i));
      cyc(0, 0, 1, 0);
    end
    check("ovf ninth absent", 32'(tvalid_o[0]), 32'd0);

    // Full with simultaneous push and pop
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, W'(8'h80 + i), 0, 0);
    cyc(1, 8'hEE, 1, 0);
    check("fullpp level", 32'(level_o[0]), 32'd8);
    check("fullpp ovf", 32'(ovf_o[0]), 32'd0);
    check("fullpp frz ovf", 32'(ovf_o[1]), 32'd0);
    for (int i = 0; i < 7; i++) exp_tail[i] = W'(8'h81 + i);
    exp_tail[7] = 8'hEE;
    for (int i = 0; i < 8; i++) begin
      check("fullpp drain", 32'(tdata_o[0]), 32'(exp_tail[i]));
      cyc(0, 0, 1, 0);
    end

    // Clear wins over simultaneous push and pop
    cyc(1, 8'h01, 0, 0); cyc(1, 8'h02, 0, 0);
    cyc(1, 8'h77, 1, 1);
    check("clr level", 32'(level_o[0]), 32'd0);
    check("clr tvalid", 32'(tvalid_o[0]), 32'd0);

    // Freeze
    for (int i = 0; i < 10; i++) cyc(1, W'(8'h40 + i), 0, 0);
    check("frz level", 32'(level_o[1]), 32'd8);
    check("frz ovf", 32'(ovf_o[1]), 32'd1);
`ifdef WB_TRACE_OVF_CNT_EN
    check("frz cnt", 32'(cnt_o[1]), 32'd2);
`endif
    for (int i = 0; i < 8; i++) begin
      check("frz drain", 32'(tdata_o[1]), 32'(8'h40 + i));
      cyc(0, 0, 1, 0);
    end
    check("frz empty", 32'(tvalid_o[1]), 32'd0);
    cyc(1, 8'h55, 0, 0);
    check("frz ignored", 32'(level_o[1]), 32'd0);
    check("run accepted", 32'(level_o[0]), 32'd1);
    cyc(0, 0, 0, 1);
    check("frz clr ovf", 32'(ovf_o[1]), 32'd0);
    cyc(1, 8'h55, 0, 0);
    check("frz resumed", 32'(tdata_o[1]), 32'h55);

    // Wrap with interleaved pops, level bounded at 3
    cyc(0, 0, 0, 1);
    nexp = 0; maxlvl = 0;
    for (int i = 0; i < 3; i++) cyc(1, W'(8'h60 + i), 0, 0);
    for (int i = 3; i < 20; i++) begin
      check("wrap order", 32'(tdata_o[0]), 32'(8'h60 + nexp));
      cyc(1, W'(8'h60 + i), 1, 0);
      nexp++;
      if (int'(level_o[0]) > maxlvl) maxlvl = int'(level_o[0]);
    end
    for (int k = 0; k < 10 && nexp < 20; k++) begin
      check("wrap order", 32'(tdata_o[0]), 32'(8'h60 + nexp));
      cyc(0, 0, 1, 0);
      nexp++;
    end
    check("wrap all out", 32'(nexp), 32'd20);
    check("wrap max level", 32'(maxlvl), 32'd3);

    // Asynchronous reset mid-operation
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, W'(8'hB0 + i), 0, 0);
    check("arst pre level", 32'(level_o[0]), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("arst tvalid", 32'(tvalid_o[0]), 32'd0);
    check("arst level", 32'(level_o[0]), 32'd0);
    check("arst tdata", 32'(tdata_o[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 8'hAA, 0, 0);
    check("arst first", 32'(tdata_o[0]), 32'hAA);
    check("arst level1", 32'(level_o[0]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_trace.md
WB_TRACE -- requirements
Module: wb_trace

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the FIFO entry count; legal values are powers of two from 2 to 64.
REQ-002 Parameter FREEZE, default 0, SHALL select halt-on-overflow (1) or keep-running (0).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 we  input  1  SHALL be the processor write-back strobe; one capture request per cycle when high.
REQ-006 wd  input  `WIDTH+1  SHALL be the processor write-back data, sampled when we=1.
REQ-007 clr  input  1  SHALL be the synchronous clear: empties the FIFO, clears ovf, returns to RUN.
REQ-008 tready  input  1  SHALL be the host-side ready.
REQ-009 tvalid  output  1  SHALL be high while the FIFO holds at least one entry.
REQ-010 tdata  output  `WIDTH+1  SHALL carry the oldest stored entry.
REQ-011 level  output  $clog2(DEPTH)+1  SHALL give the current entry count, 0..DEPTH.
REQ-012 full  output  1  SHALL be high when level==DEPTH.
REQ-013 ovf  output  1  SHALL be the sticky flag set when a capture is dropped.

Function
REQ-014 A host transfer SHALL occur in each cycle where tvalid=1 and tready=1; the head entry is popped at that edge.
REQ-015 tdata SHALL hold stable while tvalid=1 and tready=0.
REQ-016 In RUN, we=1 SHALL write wd at the tail; the entry is visible on tdata/tvalid one cycle later (FIFO was empty) or when it reaches the head.
REQ-017 Pointers SHALL wrap modulo DEPTH; level SHALL equal pushes minus pops with no off-by-one at wrap.
REQ-018 Push and pop in the same cycle with 0<level<DEPTH SHALL leave level unchanged.
REQ-019 Push with full=1 and a pop in the same cycle SHALL be accepted, and level SHALL stay DEPTH.
REQ-020 Push with full=1 and no pop SHALL be dropped, contents SHALL be unchanged, and ovf SHALL be set.
REQ-021 Pop with level==0 SHALL be impossible, because tvalid=0; tready SHALL be ignored.
REQ-022 State machine: RUN (capture enabled) and HALT (captures ignored, draining allowed).
REQ-023 RUN->HALT SHALL occur on a dropped push when FREEZE=1; with FREEZE=0 the block SHALL remain in RUN.
REQ-024 HALT->RUN SHALL occur only on clr=1.
REQ-025 clr=1 SHALL take priority over a simultaneous push and pop: after the edge, level=0, tvalid=0, ovf=0, state RUN.
REQ-026 we=1 in HALT SHALL not set ovf again and SHALL not change the FIFO.

Reset
REQ-027 rst=1 SHALL asynchronously force: pointers 0, level 0, tvalid 0, full 0, ovf 0, state RUN, tdata 0.
REQ-028 rst asserted mid-transfer SHALL discard all stored entries; the first capture after rst deassertion SHALL be entry 0 at the head.
REQ-029 FIFO storage need not be reset, but tdata SHALL read 0 while level==0.

Configuration
REQ-030 Macro WB_TRACE_OVF_CNT_EN, when defined, SHALL add output ovf_cnt (8 bits) that counts dropped pushes and saturates at 255.
REQ-031 ovf_cnt SHALL clear on rst and on clr.
REQ-032 In HALT, ovf_cnt SHALL count each we=1 as a dropped push.
REQ-033 Without WB_TRACE_OVF_CNT_EN, the ovf_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Basic order: DEPTH=8, tready=0, push 0x11,0x22,0x33 -> level=3; then tready=1 -> tdata 0x11,0x22,0x33 on consecutive cycles, then tvalid=0.
REQ-035 Full/overflow: FREEZE=0, 9 pushes with tready=0 -> full=1, level=8, ovf=1, ovf_cnt=1, ninth value absent on drain.
REQ-036 Full with simultaneous pop: level=8, we=1 and tready=1 in one cycle -> level stays 8, the new word is last out, ovf=0.
REQ-037 Freeze: FREEZE=1, 10 pushes with tready=0 -> HALT after the 9th; drain 8 words; push 0x55 -> ignored, level=0; clr -> RUN, ovf=0; push 0x55 -> tdata=0x55.
REQ-038 Wrap: 20 pushes interleaved with pops at level<=3 -> every word is out in order, level never exceeds 3.
REQ-039 Reset mid-operation: level=5, assert rst between edges -> tvalid=0, level=0 immediately; after release, push 0xAA -> tdata=0xAA.
